// File: rtl/rvv_group_sequencer_if.sv
// Request/micro-op bundle between decode, the LMUL group sequencer and the
// vRegFile/vALU pipeline. The sequencer takes the slave side; decode and the
// downstream pipeline together form the master side.
interface rvv_group_sequencer_if #(
  parameter int VLEN  = 64,
  parameter int AVL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_vset;
  logic [2:0]        in_sew;
  logic [2:0]        in_lmul;
  logic [AVL_W-1:0]  in_avl;
  logic [4:0]        in_vs1;
  logic [4:0]        in_vs2;
  logic [4:0]        in_vd;
  logic [3:0]        in_op;
  logic              uop_valid;
  logic              uop_ready;
  logic [4:0]        uop_raA;
  logic [4:0]        uop_raB;
  logic [4:0]        uop_wa;
  logic [3:0]        uop_op;
  logic [2:0]        uop_sew;
  logic [VLEN/8-1:0] uop_mask;
  logic              uop_last;

  modport master (
    output in_valid, in_vset, in_sew, in_lmul, in_avl, in_vs1, in_vs2, in_vd, in_op,
    output uop_ready,
    input  in_ready,
    input  uop_valid, uop_raA, uop_raB, uop_wa, uop_op, uop_sew, uop_mask, uop_last
  );

  modport slave (
    input  in_valid, in_vset, in_sew, in_lmul, in_avl, in_vs1, in_vs2, in_vd, in_op,
    input  uop_ready,
    output in_ready,
    output uop_valid, uop_raA, uop_raB, uop_wa, uop_op, uop_sew, uop_mask, uop_last
  );
endinterface

// File: rtl/rvv_group_sequencer.sv
// LMUL group sequencer: holds vl/vtype, executes vsetvl-type requests and
// expands each arithmetic instruction into one micro-op per group register
// with a byte-enable mask covering only body elements.
// Optional build macro RVV_VL_SKIP_EN: when defined, registers lying wholly
// past vl are not issued; otherwise all 2^lmul micro-ops are issued and the
// tail registers carry an all-zero mask.
module rvv_group_sequencer #(
  parameter int VLEN  = 64,
  parameter int AVL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rvv_group_sequencer_if.slave  bus,
  output logic [$clog2(VLEN):0] vl,
  output logic [6:0]            vtype,
  output logic                  illegal
);
  localparam int VL_W = $clog2(VLEN) + 1;
  localparam int NB   = VLEN / 8;
  localparam int DW   = VL_W + 3;
  localparam int CW   = (AVL_W > VL_W) ? AVL_W : VL_W;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [VL_W-1:0] r_vl;
  logic            r_vill;
  logic [1:0]      r_sew;
  logic [1:0]      r_lmul;
  logic [4:0]      r_vs1;
  logic [4:0]      r_vs2;
  logic [4:0]      r_vd;
  logic [3:0]      r_op;
  logic [2:0]      r_k;
  logic            r_illegal;

  logic            w_accept;
  logic            w_uopFire;
  logic            w_last;
  logic            w_vsetLegal;
  logic [CW-1:0]   w_vlmax;
  logic [CW-1:0]   w_avl;
  logic [VL_W-1:0] w_newVl;
  logic [5:0]      w_grp;
  logic [4:0]      w_grpMask;
  logic            w_arithBad;
  logic [VL_W-1:0] w_epr;
  logic [DW-1:0]   w_done;
  logic [DW-1:0]   w_rem;
  logic [DW-1:0]   w_active;
  logic [DW-1:0]   w_bytes;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_uopFire = (r_state == ISSUE) && bus.uop_ready;

  assign vl      = r_vl;
  assign vtype   = {r_vill, 1'b0, r_sew, 1'b0, r_lmul};
  assign illegal = r_illegal;

  // Request decode: new vl for a vset, legality of an arithmetic group.
  always_comb begin
    w_vsetLegal = !bus.in_sew[2] && !bus.in_lmul[2];
    w_vlmax     = CW'((NB >> bus.in_sew[1:0]) << bus.in_lmul[1:0]);
    w_avl       = CW'(bus.in_avl);
    w_newVl     = (w_avl < w_vlmax) ? VL_W'(w_avl) : VL_W'(w_vlmax);
    w_grp       = 6'd1 << r_lmul;
    w_grpMask   = 5'(w_grp - 6'd1);
    w_arithBad  = r_vill
                  || (|(bus.in_vs1 & w_grpMask))
                  || (|(bus.in_vs2 & w_grpMask))
                  || (|(bus.in_vd & w_grpMask))
                  || (({1'b0, bus.in_vd} + w_grp) > 6'd32);
  end

  // Current micro-op geometry: body bytes of register k and whether it ends the group.
  always_comb begin
    w_epr    = VL_W'(NB >> r_sew);
    w_done   = DW'(r_k) * DW'(w_epr);
    w_rem    = (DW'(r_vl) > w_done) ? (DW'(r_vl) - w_done) : '0;
    w_active = (w_rem < DW'(w_epr)) ? w_rem : DW'(w_epr);
    w_bytes  = w_active << r_sew;
`ifdef RVV_VL_SKIP_EN
    w_last   = ((w_done + DW'(w_epr)) >= DW'(r_vl));
`else
    w_last   = (r_k == 3'(w_grp - 6'd1));
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // FSM next state: enter ISSUE on a legal non-empty group, leave on the last handshake.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept && !bus.in_vset && !w_arithBad && (r_vl != '0)) w_nextState = ISSUE;
      ISSUE:   if (w_uopFire && w_last) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: every micro-op field derives only from registered state, zero outside ISSUE.
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.uop_valid = (r_state == ISSUE);
    bus.uop_raA   = '0;
    bus.uop_raB   = '0;
    bus.uop_wa    = '0;
    bus.uop_op    = '0;
    bus.uop_sew   = '0;
    bus.uop_mask  = '0;
    bus.uop_last  = 1'b0;
    if (r_state == ISSUE) begin
      bus.uop_raA  = r_vs1 + {2'b00, r_k};
      bus.uop_raB  = r_vs2 + {2'b00, r_k};
      bus.uop_wa   = r_vd + {2'b00, r_k};
      bus.uop_op   = r_op;
      bus.uop_sew  = {1'b0, r_sew};
      bus.uop_last = w_last;
      for (int i = 0; i < NB; i++) bus.uop_mask[i] = (DW'(i) < w_bytes);
    end
  end

  // CSR state, latched instruction, micro-op index and the illegal pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vl      <= '0;
      r_vill    <= 1'b1;
      r_sew     <= '0;
      r_lmul    <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vd      <= '0;
      r_op      <= '0;
      r_k       <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (w_accept && bus.in_vset) begin
        if (w_vsetLegal) begin
          r_vill <= 1'b0;
          r_vl   <= w_newVl;
          r_sew  <= bus.in_sew[1:0];
          r_lmul <= bus.in_lmul[1:0];
        end else begin
          r_vill    <= 1'b1;
          r_vl      <= '0;
          r_sew     <= '0;
          r_lmul    <= '0;
          r_illegal <= 1'b1;
        end
      end else if (w_accept) begin
        if (w_arithBad) begin
          r_illegal <= 1'b1;
        end else begin
          r_vs1 <= bus.in_vs1;
          r_vs2 <= bus.in_vs2;
          r_vd  <= bus.in_vd;
          r_op  <= bus.in_op;
          r_k   <= '0;
        end
      end else if (w_uopFire) begin
        r_k <= r_k + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_rvv_group_sequencer.sv
// Self-checking bench for rvv_group_sequencer at VLEN=64: a directed table,
// hand-written stall and reset sequences, and randomized traffic checked
// against an element-level model of vl/vtype and group expansion.
module tb_rvv_group_sequencer;
  localparam int VLEN  = 64;
  localparam int AVL_W = 8;
  localparam int VL_W  = $clog2(VLEN) + 1;
  localparam int NB    = VLEN / 8;
  localparam int NV    = 18;

`ifdef RVV_VL_SKIP_EN
  localparam int E5_CNT = 1, E5_LAST = 'hFF, E8_CNT = 3, E8_LAST = 'h0F;
`else
  localparam int E5_CNT = 2, E5_LAST = 'h00, E8_CNT = 4, E8_LAST = 'h00;
`endif

  typedef struct {
    bit isVset;
    int sew, lmul, avl, vs1, vs2, vd, op;
    int expVl, expVtype, expIll, expCount, expLastMask;
  } vec_t;

  typedef struct {
    int raA, raB, wa, op, sew, mask, last;
  } uop_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [VL_W-1:0] vl;
  logic [6:0]      vtype;
  logic            illegal;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   mVl, mSew, mLmul;
  bit   mVill;
  int   obsCount, obsLastMask, obsIll;
  uop_t expQ[$];
  vec_t vecs[NV];

  rvv_group_sequencer_if #(.VLEN(VLEN), .AVL_W(AVL_W)) bus ();

  rvv_group_sequencer #(.VLEN(VLEN), .AVL_W(AVL_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .vl      (vl),
    .vtype   (vtype),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Hard stop in case something inside a loop misbehaves.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int packUop(uop_t u);
    return (u.raA << 26) | (u.raB << 21) | (u.wa << 16) | (u.op << 12) | (u.sew << 9) | (u.mask << 1) | u.last;
  endfunction

  function automatic int modelVtype();
    return (mVill ? 64 : 0) + mSew * 8 + mLmul;
  endfunction

  // vset: vl = min(AVL, LMUL*VLEN/SEW); illegal encodings set vill and clear vl.
  function automatic bit modelVset(int sew, int lmul, int avl);
    int vlmax;
    expQ.delete();
    if (sew > 3 || lmul > 3) begin
      mVill = 1'b1; mVl = 0; mSew = 0; mLmul = 0;
      return 1'b1;
    end
    vlmax = (VLEN * (1 << lmul)) / (8 * (1 << sew));
    mVill = 1'b0; mSew = sew; mLmul = lmul;
    mVl   = (avl < vlmax) ? avl : vlmax;
    return 1'b0;
  endfunction

  // Arithmetic: expected micro-op list built element by element from vl.
  function automatic bit modelArith(int vs1, int vs2, int vd, int op);
    int n, sb, epr, cnt;
    uop_t u;
    expQ.delete();
    n = 1 << mLmul;
    if (mVill || (vs1 % n) != 0 || (vs2 % n) != 0 || (vd % n) != 0 || (vd + n) > 32) return 1'b1;
    if (mVl == 0) return 1'b0;
    sb  = 1 << mSew;
    epr = NB / sb;
`ifdef RVV_VL_SKIP_EN
    cnt = (mVl + epr - 1) / epr;
`else
    cnt = n;
`endif
    for (int k = 0; k < cnt; k++) begin
      u.raA = vs1 + k; u.raB = vs2 + k; u.wa = vd + k;
      u.op = op; u.sew = mSew; u.mask = 0;
      for (int b = 0; b < NB; b++) if ((k * epr + b / sb) < mVl) u.mask |= (1 << b);
      u.last = (k == cnt - 1) ? 1 : 0;
      expQ.push_back(u);
    end
    return 1'b0;
  endfunction

  // Issue one request at a negedge and follow it to completion.
  // readyMode: 0 = uop_ready high, 1 = random, 2 = three stall cycles on micro-op 1.
  task automatic applyStimulus(input bit isVset, input int sew, input int lmul, input int avl,
                               input int vs1, input int vs2, input int vd, input int op,
                               input int readyMode);
    bit   expIll;
    bit   rdy;
    bit   sampledValid;
    int   cyc;
    int   stalls;
    uop_t got;
    checkOutput("inReadyIdle", bus.in_ready, 1);
    if (isVset) expIll = modelVset(sew, lmul, avl);
    else        expIll = modelArith(vs1, vs2, vd, op);
    bus.in_valid = 1'b1;
    bus.in_vset  = isVset;
    bus.in_sew   = 3'(sew);
    bus.in_lmul  = 3'(lmul);
    bus.in_avl   = AVL_W'(avl);
    bus.in_vs1   = 5'(vs1);
    bus.in_vs2   = 5'(vs2);
    bus.in_vd    = 5'(vd);
    bus.in_op    = 4'(op);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    obsIll = illegal;
    obsCount = 0;
    obsLastMask = 0;
    checkOutput("illegal", illegal, expIll);
    if (isVset) begin
      checkOutput("vl", vl, mVl);
      checkOutput("vtype", vtype, modelVtype());
    end
    cyc = 0;
    stalls = 0;
    while (expQ.size() > 0 && cyc < 200) begin
      sampledValid = bus.uop_valid;
      checkOutput("uopValid", sampledValid, 1);
      got.raA = bus.uop_raA; got.raB = bus.uop_raB; got.wa = bus.uop_wa;
      got.op = bus.uop_op; got.sew = bus.uop_sew; got.mask = bus.uop_mask; got.last = bus.uop_last;
      checkOutput("uopFields", packUop(got), packUop(expQ[0]));
      case (readyMode)
        1:       rdy = ($urandom_range(0, 1) == 1);
        2:       rdy = !(obsCount == 1 && stalls < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stalls++;
      bus.uop_ready = rdy;
      if (rdy && sampledValid) begin
        obsCount++;
        obsLastMask = got.mask;
      end
      @(posedge clk);
      if (rdy && sampledValid) void'(expQ.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.uop_ready = 1'b0;
    checkOutput("uopQueueDrained", expQ.size(), 0);
    checkOutput("uopIdleAfter", bus.uop_valid, 0);
  endtask

  initial begin
    // Directed vectors: {kind, sew, lmul, avl, vs1, vs2, vd, op, vl, vtype, illegal, uops, last mask}
    vecs[0]  = '{1, 0, 3, 100, 0, 0, 0, 0, 64, 'b0000011, 0, 0, 0};
    vecs[1]  = '{1, 2, 1, 3,   0, 0, 0, 0, 3,  'b0010001, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0,   2, 4, 6, 5, 0, 0, 0, 2, 'h0F};
    vecs[3]  = '{1, 2, 1, 2,   0, 0, 0, 0, 2,  'b0010001, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0,   2, 4, 6, 7, 0, 0, 0, E5_CNT, E5_LAST};
    vecs[5]  = '{1, 0, 2, 20,  0, 0, 0, 0, 20, 'b0000010, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0,   0, 4, 5, 1, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 0,   4, 8, 28, 2, 0, 0, 0, E8_CNT, E8_LAST};
    vecs[8]  = '{1, 5, 0, 10,  0, 0, 0, 0, 0,  'b1000000, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0,   0, 0, 0, 3, 0, 0, 1, 0, 0};
    vecs[10] = '{1, 3, 0, 0,   0, 0, 0, 0, 0,  'b0011000, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0,   0, 0, 0, 4, 0, 0, 0, 0, 0};
    vecs[12] = '{1, 1, 4, 9,   0, 0, 0, 0, 0,  'b1000000, 1, 0, 0};
    vecs[13] = '{1, 3, 3, 255, 0, 0, 0, 0, 8,  'b0011011, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 0,   8, 16, 24, 9, 0, 0, 0, 8, 'hFF};
    vecs[15] = '{1, 1, 0, 3,   0, 0, 0, 0, 3,  'b0001000, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 0,   1, 1, 1, 6, 0, 0, 0, 1, 'h3F};
    vecs[17] = '{0, 0, 0, 0,   3, 1, 2, 6, 0, 0, 0, 1, 'h3F};

    bus.in_valid = 1'b0; bus.in_vset = 1'b0; bus.in_sew = '0; bus.in_lmul = '0;
    bus.in_avl = '0; bus.in_vs1 = '0; bus.in_vs2 = '0; bus.in_vd = '0; bus.in_op = '0;
    bus.uop_ready = 1'b0;
    mVl = 0; mSew = 0; mLmul = 0; mVill = 1'b1;

    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstVl", vl, 0);
    checkOutput("rstVtype", vtype, 'h40);
    checkOutput("rstIllegal", illegal, 0);
    checkOutput("rstUopValid", bus.uop_valid, 0);
    checkOutput("rstInReady", bus.in_ready, 1);
    checkOutput("rstUopMask", bus.uop_mask, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].isVset, vecs[i].sew, vecs[i].lmul, vecs[i].avl,
                    vecs[i].vs1, vecs[i].vs2, vecs[i].vd, vecs[i].op, 0);
      checkOutput("tblIllegal", obsIll, vecs[i].expIll);
      if (vecs[i].isVset) begin
        checkOutput("tblVl", vl, vecs[i].expVl);
        checkOutput("tblVtype", vtype, vecs[i].expVtype);
      end else begin
        checkOutput("tblUopCount", obsCount, vecs[i].expCount);
        checkOutput("tblLastMask", obsLastMask, vecs[i].expLastMask);
      end
    end

    // Stall of three cycles in the middle of a four-register group.
    applyStimulus(1, 0, 2, 30, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4, 8, 9, 2);
    checkOutput("stallUopCount", obsCount, 4);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int s, l, a, n, r1, r2, rd;
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      a = $urandom_range(0, 255);
      applyStimulus(1, s, l, a, 0, 0, 0, 0, 1);
      for (int j = 0; j < 2; j++) begin
        n  = 1 << mLmul;
        r1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : (int'($urandom_range(0, 31)) / n) * n;
        r2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : (int'($urandom_range(0, 31)) / n) * n;
        rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : (int'($urandom_range(0, 31)) / n) * n;
        applyStimulus(0, 0, 0, 0, r1, r2, rd, int'($urandom_range(0, 15)), 1);
      end
    end

    // Reset asserted in the middle of an eight-register group.
    applyStimulus(1, 0, 3, 64, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b1; bus.in_vset = 1'b0;
    bus.in_vs1 = 5'd0; bus.in_vs2 = 5'd8; bus.in_vd = 5'd16; bus.in_op = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("midGroupValid", bus.uop_valid, 1);
    bus.uop_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.uop_ready = 1'b0;
    checkOutput("midGroupRaA", bus.uop_raA, 1);
    rst = 1'b0;
    #1;
    checkOutput("asyncRstUopValid", bus.uop_valid, 0);
    checkOutput("asyncRstVl", vl, 0);
    checkOutput("asyncRstVtype", vtype, 'h40);
    checkOutput("asyncRstInReady", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    mVill = 1'b1; mVl = 0; mSew = 0; mLmul = 0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("postRstArithIllegal", obsIll, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
